fetch_sequencer: RTL and testbench

Control sequencer for the fetch stage. Each cycle it decides whether the program counter advances, which next-PC source the fetch unit uses (sequential, branch, jump or jump-register) and whether the IF/ID register loads, holds or takes a bubble. Its inputs are ID-stage redirect requests, a load-use hazard stall and the instruction-memory ready signal. It sits between the ID-stage decode/compare logic and the fetch unit, and also provides sticky error and performance counters.

---
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage PC / IF-ID control with memory timeout detection and perf counters
module fetch_sequencer #(
  parameter int RESET_HOLD = 2,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_branch,
  input  logic             id_zero,
  input  logic             id_jump,
  input  logic             id_jumpR,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  output logic             pc_en,
  output logic             branch,
  output logic             jump,
  output logic             jumpR,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             fetch_busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, MEMWAIT, ERROR} state_t;
  state_t state_q, state_d;
  logic [3:0] boot_q, boot_d;
  logic [7:0] wait_q, wait_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d, stall_cnt_q, stall_cnt_d;
  logic timeout_err_q, timeout_err_d;
  logic redirect, active, take;
  // Decode control outputs and next state; hazard beats redirect beats memory
  always_comb begin
    redirect = id_jumpR | id_jump | (id_branch & ~id_zero);
    active = (state_q == RUN) || (state_q == MEMWAIT);
    pc_en = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    jumpR = 1'b0;
    ifid_en = 1'b0;
    ifid_flush = 1'b1;
    take = 1'b0;
    state_d = state_q;
    boot_d = boot_q;
    wait_d = wait_q;
    if (state_q == BOOT) begin
      boot_d = boot_q + 4'd1;
      state_d = (boot_q == 4'(RESET_HOLD - 1)) ? RUN : BOOT;
    end else if (active) begin
      if (hazard_stall) begin
        ifid_flush = 1'b0;
      end else if (redirect) begin
        pc_en = 1'b1;
        jumpR = id_jumpR;
        jump = ~id_jumpR & id_jump;
        branch = ~id_jumpR & ~id_jump;
        take = 1'b1;
        state_d = RUN;
        wait_d = 8'd0;
      end else if (imem_ready) begin
        pc_en = 1'b1;
        ifid_en = 1'b1;
        ifid_flush = 1'b0;
        state_d = RUN;
        wait_d = 8'd0;
      end else begin
        wait_d = wait_q + 8'd1;
        state_d = (wait_d == 8'(MAX_WAIT)) ? ERROR : MEMWAIT;
      end
    end
    redirect_cnt_d = (take && !(&redirect_cnt_q)) ? redirect_cnt_q + CNT_W'(1) : redirect_cnt_q;
    stall_cnt_d = (active && !pc_en && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    timeout_err_d = timeout_err_q | (state_d == ERROR);
  end
  // State, counters and sticky error register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      boot_q <= 4'd0;
      wait_q <= 8'd0;
      redirect_cnt_q <= '0;
      stall_cnt_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q <= boot_d;
      wait_q <= wait_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign fetch_busy = (state_q == BOOT) || (state_q == MEMWAIT);
  assign timeout_err = timeout_err_q;
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized and directed checks of fetch_sequencer against a cycle model
module tb_fetch_sequencer;
  localparam int RH = 2;
  localparam int MW = 15;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_branch = 1'b0, id_zero = 1'b0, id_jump = 1'b0, id_jumpR = 1'b0;
  logic hazard_stall = 1'b0, imem_ready = 1'b0;
  logic pc_en, branch, jump, jumpR, ifid_en, ifid_flush, fetch_busy, timeout_err;
  logic [CW-1:0] redirect_cnt, stall_cnt;
  int checks = 0;
  int errors = 0;
  int boot_left, nr, m_redir, m_stall;
  bit m_err, m_to;
  logic e_pc, e_br, e_j, e_jr, e_en, e_fl, e_busy;

  fetch_sequencer #(.RESET_HOLD(RH), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_branch(id_branch), .id_zero(id_zero), .id_jump(id_jump),
    .id_jumpR(id_jumpR), .hazard_stall(hazard_stall), .imem_ready(imem_ready), .pc_en(pc_en),
    .branch(branch), .jump(jump), .jumpR(jumpR), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .fetch_busy(fetch_busy), .timeout_err(timeout_err), .redirect_cnt(redirect_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  // Drive one cycle of inputs and predict the combinational controls
  task automatic tick(input logic b, z, j, jr, h, r);
    logic rd;
    id_branch = b; id_zero = z; id_jump = j; id_jumpR = jr; hazard_stall = h; imem_ready = r;
    #1;
    rd = jr | j | (b & ~z);
    e_pc = 0; e_br = 0; e_j = 0; e_jr = 0; e_en = 0; e_fl = 1; e_busy = 0;
    if (boot_left > 0) e_busy = 1;
    else if (!m_err) begin
      e_busy = (nr > 0);
      if (h) e_fl = 0;
      else if (rd) begin
        e_pc = 1; e_jr = jr; e_j = !jr && j; e_br = !jr && !j;
      end else if (r) begin
        e_pc = 1; e_en = 1; e_fl = 0;
      end
    end
  endtask

  // Take one clock edge and update the model from the inputs seen at that edge
  task automatic advance();
    logic rd;
    @(posedge clk);
    rd = id_jumpR | id_jump | (id_branch & ~id_zero);
    if (boot_left > 0) boot_left--;
    else if (!m_err) begin
      if (hazard_stall) m_stall = sat(m_stall + 1);
      else if (rd) begin
        m_redir = sat(m_redir + 1); nr = 0;
      end else if (imem_ready) nr = 0;
      else begin
        nr++; m_stall = sat(m_stall + 1);
        if (nr == MW) begin m_err = 1; m_to = 1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    id_branch = 0; id_zero = 0; id_jump = 0; id_jumpR = 0; hazard_stall = 0; imem_ready = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    boot_left = RH; nr = 0; m_redir = 0; m_stall = 0; m_err = 0; m_to = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({pc_en, ifid_en, ifid_flush, branch, jump, jumpR, fetch_busy, timeout_err} !== 8'b00100010 ||
        redirect_cnt !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_values got pc=%b en=%b fl=%b sel=%b%b%b busy=%b to=%b rc=%0d sc=%0d exp 0 0 1 000 1 0 0 0",
               pc_en, ifid_en, ifid_flush, branch, jump, jumpR, fetch_busy, timeout_err, redirect_cnt, stall_cnt);
    end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0, 0, 1);
      checks++;
      if (pc_en !== (i >= RH) || ifid_flush !== (i < RH) || fetch_busy !== (i < RH)) begin
        errors++;
        $display("FAIL boot_cycle%0d got pc=%b fl=%b busy=%b exp pc=%b fl=%b busy=%b",
                 i, pc_en, ifid_flush, fetch_busy, i >= RH, i < RH, i < RH);
      end
      advance();
    end
  endtask

  task automatic test_branch();
    tick(1, 0, 0, 0, 0, 1);
    checks++;
    if ({branch, jump, jumpR, pc_en, ifid_flush} !== 5'b10011) begin
      errors++;
      $display("FAIL branch_taken got sel=%b%b%b pc=%b fl=%b exp sel=100 pc=1 fl=1", branch, jump, jumpR, pc_en, ifid_flush);
    end
    advance();
    checks++;
    if (redirect_cnt !== 8'd1) begin
      errors++;
      $display("FAIL branch_cnt got %0d exp 1", redirect_cnt);
    end
    tick(1, 1, 0, 0, 0, 1);
    checks++;
    if ({branch, jump, jumpR, pc_en, ifid_en, ifid_flush} !== 6'b000110) begin
      errors++;
      $display("FAIL branch_not_taken got sel=%b%b%b pc=%b en=%b fl=%b exp sel=000 pc=1 en=1 fl=0",
               branch, jump, jumpR, pc_en, ifid_en, ifid_flush);
    end
    advance();
    checks++;
    if (redirect_cnt !== 8'd1) begin
      errors++;
      $display("FAIL branch_not_taken_cnt got %0d exp 1", redirect_cnt);
    end
  endtask

  task automatic test_hazard_redirect();
    int s0;
    s0 = m_stall;
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 1, 1, 1, 1);
      checks++;
      if ({pc_en, branch, jump, jumpR, ifid_en, ifid_flush} !== 6'b0) begin
        errors++;
        $display("FAIL hazard_hold%0d got pc=%b sel=%b%b%b en=%b fl=%b exp all 0",
                 i, pc_en, branch, jump, jumpR, ifid_en, ifid_flush);
      end
      advance();
    end
    tick(0, 0, 1, 1, 0, 1);
    checks++;
    if ({branch, jump, jumpR, pc_en, ifid_flush} !== 5'b00111) begin
      errors++;
      $display("FAIL hazard_release got sel=%b%b%b pc=%b fl=%b exp sel=001 pc=1 fl=1", branch, jump, jumpR, pc_en, ifid_flush);
    end
    advance();
    checks++;
    if (int'(stall_cnt) !== s0 + 2) begin
      errors++;
      $display("FAIL hazard_stall_cnt got %0d exp %0d", stall_cnt, s0 + 2);
    end
  endtask

  task automatic test_memwait();
    int s0;
    s0 = m_stall;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      checks++;
      if (pc_en !== 1'b0 || ifid_flush !== 1'b1 || fetch_busy !== (i > 0)) begin
        errors++;
        $display("FAIL memwait%0d got pc=%b fl=%b busy=%b exp pc=0 fl=1 busy=%b", i, pc_en, ifid_flush, fetch_busy, i > 0);
      end
      advance();
    end
    tick(0, 0, 0, 0, 0, 1);
    advance();
    checks++;
    if (fetch_busy !== 1'b0 || timeout_err !== 1'b0 || int'(stall_cnt) !== s0 + 3) begin
      errors++;
      $display("FAIL memwait_exit got busy=%b to=%b sc=%0d exp busy=0 to=0 sc=%0d", fetch_busy, timeout_err, stall_cnt, s0 + 3);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MW - 1; i++) begin tick(0, 0, 0, 0, 0, 0); advance(); end
    tick(0, 0, 0, 0, 0, 1);
    advance();
    checks++;
    if (timeout_err !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_boundary got to=%b busy=%b exp to=0 busy=0", timeout_err, fetch_busy);
    end
    for (int i = 0; i < MW; i++) begin tick(0, 0, 0, 0, 0, 0); advance(); end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set got to=%b exp 1", timeout_err);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 0, 1);
      checks++;
      if (pc_en !== 1'b0 || jump !== 1'b0 || ifid_flush !== 1'b1 || timeout_err !== 1'b1) begin
        errors++;
        $display("FAIL error_sticky%0d got pc=%b j=%b fl=%b to=%b exp pc=0 j=0 fl=1 to=1", i, pc_en, jump, ifid_flush, timeout_err);
      end
      advance();
    end
    apply_reset();
    checks++;
    if (timeout_err !== 1'b0 || fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL error_reset got to=%b busy=%b exp to=0 busy=1", timeout_err, fetch_busy);
    end
    release_reset();
  endtask

  task automatic test_reset_memwait();
    for (int i = 0; i < RH; i++) begin tick(0, 0, 0, 0, 0, 1); advance(); end
    for (int i = 0; i < 4; i++) begin tick(0, 0, 0, 0, 0, 0); advance(); end
    apply_reset();
    checks++;
    if (fetch_busy !== 1'b1 || stall_cnt !== '0 || pc_en !== 1'b0 || ifid_flush !== 1'b1) begin
      errors++;
      $display("FAIL memwait_reset got busy=%b sc=%0d pc=%b fl=%b exp busy=1 sc=0 pc=0 fl=1", fetch_busy, stall_cnt, pc_en, ifid_flush);
    end
    release_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      tick(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 7));
      checks++;
      if ({pc_en, branch, jump, jumpR, ifid_flush, fetch_busy} !== {e_pc, e_br, e_j, e_jr, e_fl, e_busy} ||
          (!e_fl && ifid_en !== e_en)) begin
        errors++;
        $display("FAIL rand_ctl%0d got pc=%b sel=%b%b%b en=%b fl=%b busy=%b exp pc=%b sel=%b%b%b en=%b fl=%b busy=%b",
                 i, pc_en, branch, jump, jumpR, ifid_en, ifid_flush, fetch_busy, e_pc, e_br, e_j, e_jr, e_en, e_fl, e_busy);
      end
      advance();
      checks++;
      if ({timeout_err, redirect_cnt, stall_cnt} !== {m_to, CW'(m_redir), CW'(m_stall)}) begin
        errors++;
        $display("FAIL rand_regs%0d got to=%b rc=%0d sc=%0d exp to=%b rc=%0d sc=%0d",
                 i, timeout_err, redirect_cnt, stall_cnt, m_to, m_redir, m_stall);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    release_reset();
    for (int i = 0; i < RH; i++) begin tick(0, 0, 0, 0, 0, 1); advance(); end
    for (int i = 0; i < (1 << CW) + 3; i++) begin tick(0, 0, 1, 0, 0, 0); advance(); end
    checks++;
    if (redirect_cnt !== {CW{1'b1}} || int'(redirect_cnt) !== m_redir) begin
      errors++;
      $display("FAIL redirect_saturate got %0d exp %0d", redirect_cnt, SAT);
    end
    for (int i = 0; i < (1 << CW) + 3; i++) begin tick(0, 0, 0, 0, 1, 1); advance(); end
    checks++;
    if (stall_cnt !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL stall_saturate got %0d exp %0d", stall_cnt, SAT);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_hazard_redirect();
    test_memwait();
    test_timeout();
    test_reset_memwait();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
